// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the execute/load pipelines and the register-file writeback arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 alu_valid;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 alu_ready;
  logic                 ld_valid;
  logic [ADDR_W-1:0]    ld_rd;
  logic [DATA_W-1:0]    ld_data;
  logic                 ld_ready;
  logic                 ld_issue;
  logic [ADDR_W-1:0]    ld_issue_rd;
  logic                 we;
  logic [ADDR_W-1:0]    saddr;
  logic [DATA_W-1:0]    wdata;
  logic [2**ADDR_W-1:0] pending;
  logic                 busy;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
    input  alu_ready, ld_ready, we, saddr, wdata, pending, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
    output alu_ready, ld_ready, we, saddr, wdata, pending, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single register-file writer: arbitrates ALU results against load returns, buffers
// loads that lose arbitration, and tracks per-register outstanding loads.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] buf_rd_q   [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic full, empty, alu_win, pop, bypass, ld_acc, push, ld_wr;

  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == '0);
    alu_win = bus.alu_valid && !full;
    pop     = !empty && !alu_win;
    bypass  = empty && !alu_win && bus.ld_valid;
    ld_acc  = bus.ld_valid && (!full || pop);
    // x0 loads are acknowledged but never occupy a buffer slot
    push    = ld_acc && !bypass && (bus.ld_rd != '0);

    we_d    = 1'b0;
    saddr_d = saddr_q;
    wdata_d = wdata_q;
    if (alu_win) begin
      we_d    = (bus.alu_rd != '0);
      saddr_d = bus.alu_rd;
      wdata_d = bus.alu_data;
    end else if (pop) begin
      we_d    = 1'b1;
      saddr_d = buf_rd_q[head_q];
      wdata_d = buf_data_q[head_q];
    end else if (bypass) begin
      we_d    = (bus.ld_rd != '0);
      saddr_d = bus.ld_rd;
      wdata_d = bus.ld_data;
    end
    ld_wr = !alu_win && we_d;

    // Issue is applied after the clear so a same-cycle set survives
    pending_d = pending_q;
    if (ld_wr) pending_d[saddr_d] = 1'b0;
    if (bus.ld_issue) pending_d[bus.ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    head_d = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      saddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      we_q      <= we_d;
      saddr_q   <= saddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd_q[tail_q]   <= bus.ld_rd;
      buf_data_q[tail_q] <= bus.ld_data;
    end
  end

  assign bus.alu_ready = !full;
  assign bus.ld_ready  = !full || pop;
  assign bus.we        = we_q;
  assign bus.saddr     = saddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = !empty;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a queue-based writeback reference model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [ADDR_W-1:0] q_rd   [$];
  logic [DATA_W-1:0] q_data [$];
  logic [31:0]       pend;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
  endtask

  // One clock of stimulus; entered and left at posedge+1
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iss, input logic [4:0] ird);
    int          n;
    bit          alu_take, popped, byp, exp_we, ld_wb;
    logic [4:0]  ea;
    logic [31:0] ed;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_data    = ad;
    bus.ld_valid    = lv;
    bus.ld_rd       = lrd;
    bus.ld_data     = ldat;
    bus.ld_issue    = iss;
    bus.ld_issue_rd = ird;
    #1;
    n = q_rd.size();
    chk("alu_ready", 64'(bus.alu_ready), 64'(n < DEPTH));
    chk("busy", 64'(bus.busy), 64'(n != 0));
    exp_we = 0; ea = 0; ed = 0; ld_wb = 0; popped = 0; byp = 0;
    alu_take = av && (n < DEPTH);
    if (alu_take) begin
      if (ard != 0) begin exp_we = 1; ea = ard; ed = ad; end
    end else if (n > 0) begin
      exp_we = 1; ea = q_rd.pop_front(); ed = q_data.pop_front();
      popped = 1; ld_wb = 1;
    end else if (lv) begin
      byp = 1;
      if (lrd != 0) begin exp_we = 1; ea = lrd; ed = ldat; ld_wb = 1; end
    end
    chk("ld_ready", 64'(bus.ld_ready), 64'((n < DEPTH) || popped));
    if (lv && !byp && lrd != 0) begin
      q_rd.push_back(lrd);
      q_data.push_back(ldat);
    end
    if (ld_wb) pend[ea] = 1'b0;
    if (iss && ird != 0) pend[ird] = 1'b1;
    @(posedge clk);
    #1;
    chk("we", 64'(bus.we), 64'(exp_we));
    if (exp_we) begin
      chk("saddr", 64'(bus.saddr), 64'(ea));
      chk("wdata", 64'(bus.wdata), 64'(ed));
    end
    chk("pending", 64'(bus.pending), 64'(pend));
  endtask

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    pend = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_we", 64'(bus.we), 64'(0));
    chk("rst_saddr", 64'(bus.saddr), 64'(0));
    chk("rst_wdata", 64'(bus.wdata), 64'(0));
    chk("rst_pending", 64'(bus.pending), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
  endtask

  // Called at posedge+1; reset lands between edges and is released after one edge
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // idle right after release: no write
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // bypass with pending cleared
    cycle(0, 0, 0, 0, 0, 0, 1, 5);
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    chk("bypass_pend5", 64'(bus.pending[5]), 64'(0));
    // contention
    cycle(1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // full buffer with continuous ALU traffic
    cycle(1, 1, 32'hA1, 1, 6, 32'h66, 0, 0);
    cycle(1, 2, 32'hA2, 1, 7, 32'h77, 0, 0);
    cycle(1, 3, 32'hA3, 1, 8, 32'h88, 0, 0);
    cycle(1, 4, 32'hA4, 0, 0, 0, 0, 0);
    cycle(1, 5, 32'hA5, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // x0 writes
    cycle(1, 0, 32'h1234, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 32'h5678, 0, 0);
    cycle(1, 2, 32'h9, 1, 0, 32'h5678, 0, 0);
    // scoreboard: set wins over same-cycle writeback
    cycle(0, 0, 0, 0, 0, 0, 1, 9);
    cycle(0, 0, 0, 1, 9, 32'h99, 1, 9);
    chk("sb_pend9_set", 64'(bus.pending[9]), 64'(1));
    cycle(0, 0, 0, 1, 9, 32'h999, 0, 0);
    chk("sb_pend9_clr", 64'(bus.pending[9]), 64'(0));
    // reset with two entries buffered
    cycle(1, 1, 32'h1, 1, 10, 32'hAA, 1, 12);
    cycle(1, 2, 32'h2, 1, 11, 32'hBB, 0, 0);
    mid_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      int alu_pct;
      alu_pct = (i < 400) ? 80 : 35;
      cycle(($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 11)), $urandom,
            ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 11)), $urandom,
            ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 11)));
      if (i == 600) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
